// File: rtl/float_composer.sv
// -----------------------------------------------------------------------------
// float_composer
//   Converts three signed fixed-point values Q(INT_W).(FRAC_W) into IEEE-754
//   single-precision words. One shared bit-serial normalizer handles lanes
//   0, 1, 2 in turn; one job (three lanes) is in flight at a time.
//
//   Optional feature macro: FLOAT_COMPOSER_RNE_EN
//     defined   -> round-to-nearest-even on the mantissa
//     undefined -> truncation (round/sticky bits ignored)
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   in_valid   job offered on fx1..fx3
//   in_ready   high only while IDLE
//   fx1..fx3   W-bit signed fixed-point inputs (W = INT_W + FRAC_W, 25..48)
//   out_valid  f1..f3 valid, held until out_ready
//   out_ready  consumer accepts the result
//   f1..f3     float32 results (hold value until rewritten by their lane)
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module float_composer #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INT_W+FRAC_W-1:0]   fx1,
  input  logic [INT_W+FRAC_W-1:0]   fx2,
  input  logic [INT_W+FRAC_W-1:0]   fx3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               f1,
  output logic [31:0]               f2,
  output logic [31:0]               f3,
  output logic                      busy
);

  localparam int W    = INT_W + FRAC_W;
  localparam int LZ_W = $clog2(W);
  // Exponent for a value whose MSB sits at bit W-1 (lz = 0).
  localparam logic [7:0] EXP_BASE = 8'(127 + INT_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    NORM = 3'd2,
    PACK = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;

  logic [W-1:0]    fx0_r;
  logic [W-1:0]    fx1_r;
  logic [W-1:0]    fx2_r;
  logic [1:0]      lane_r;
  logic            sign_r;
  logic [W-1:0]    mag_r;
  logic [LZ_W-1:0] lz_r;

  logic [W-1:0]    sel_fx_s;
  logic [31:0]     pack_s;
  logic [7:0]      exp_s;
  logic [22:0]     mant_s;

  // Lane input multiplexer for the shared normalizer.
  always_comb begin
    sel_fx_s = fx0_r;
    case (lane_r)
      2'd0:    sel_fx_s = fx0_r;
      2'd1:    sel_fx_s = fx1_r;
      2'd2:    sel_fx_s = fx2_r;
      default: sel_fx_s = fx0_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // A zero input has nothing to normalize.
        if (sel_fx_s == '0) begin
          state_s = PACK;
        end else begin
          state_s = NORM;
        end
      end
      NORM: begin
        if (mag_r[W-1]) begin
          state_s = PACK;
        end else begin
          state_s = NORM;
        end
      end
      PACK: begin
        if (lane_r == 2'd2) begin
          state_s = DONE;
        end else begin
          state_s = LOAD;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Float assembly from the normalized magnitude of the current lane.
  always_comb begin
    exp_s  = EXP_BASE - 8'(lz_r);
    mant_s = mag_r[W-2 -: 23];
`ifdef FLOAT_COMPOSER_RNE_EN
    begin
      logic        round_v;
      logic        sticky_v;
      logic [W-1:0] low_v;
      logic [23:0] sum_v;
      round_v  = mag_r[W-25];
      // Bits below the round bit, left-justified; empty when W = 25.
      low_v    = mag_r << 25;
      sticky_v = |low_v;
      sum_v    = {1'b0, mant_s} + 24'(round_v && (sticky_v || mant_s[0]));
      if (sum_v[23]) begin
        mant_s = 23'd0;
        exp_s  = exp_s + 8'd1;
      end else begin
        mant_s = sum_v[22:0];
      end
    end
`else
    mant_s = mag_r[W-2 -: 23];
`endif
    if (mag_r == '0) begin
      // Zero is always +0, never -0.
      pack_s = 32'h0000_0000;
    end else begin
      pack_s = {sign_r, exp_s, mant_s};
    end
  end

  // Datapath, result and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fx0_r     <= '0;
      fx1_r     <= '0;
      fx2_r     <= '0;
      lane_r    <= 2'd0;
      sign_r    <= 1'b0;
      mag_r     <= '0;
      lz_r      <= '0;
      f1        <= 32'h0000_0000;
      f2        <= 32'h0000_0000;
      f3        <= 32'h0000_0000;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            fx0_r  <= fx1;
            fx1_r  <= fx2;
            fx2_r  <= fx3;
            lane_r <= 2'd0;
          end
        end
        LOAD: begin
          // Two's-complement negate; the most negative value maps to 2^(W-1).
          sign_r <= sel_fx_s[W-1];
          mag_r  <= sel_fx_s[W-1] ? (~sel_fx_s + W'(1)) : sel_fx_s;
          lz_r   <= '0;
        end
        NORM: begin
          if (!mag_r[W-1]) begin
            mag_r <= mag_r << 1;
            lz_r  <= lz_r + LZ_W'(1);
          end
        end
        PACK: begin
          case (lane_r)
            2'd0:    f1 <= pack_s;
            2'd1:    f2 <= pack_s;
            2'd2:    f3 <= pack_s;
            default: ;
          endcase
          if (lane_r != 2'd2) begin
            lane_r <= lane_r + 2'd1;
          end
        end
        DONE:    ;
        default: ;
      endcase
      out_valid <= (state_s == DONE);
      busy      <= (state_s != IDLE);
      in_ready  <= (state_s == IDLE);
    end
  end

endmodule

// File: tb/tb_float_composer.sv
// -----------------------------------------------------------------------------
// tb_float_composer
//   Self-checking bench for float_composer (default INT_W = FRAC_W = 16).
//   Table of jobs with expected floats and latency; expectations go through a
//   scoreboard queue at acceptance and are compared when out_valid rises.
//   Hand-written sequences cover backpressure and reset in the middle of a job.
// -----------------------------------------------------------------------------
module tb_float_composer;

`ifdef FLOAT_COMPOSER_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fx1, fx2, fx3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f1, f2, f3;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] fx1, fx2, fx3;
    logic [31:0] e1, e2, e3;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] e1, e2, e3;
    int          lat;
  } exp_t;

  vec_t vecs[4];
  exp_t sb_q[$];
  exp_t last_e;

  float_composer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fx1       (fx1),
    .fx2       (fx2),
    .fx3       (fx3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f1        (f1),
    .f2        (f2),
    .f3        (f3),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Offer one job, wait for the result, compare, optionally accept it.
  task automatic run_job(input vec_t v, input bit release_out);
    exp_t e;
    exp_t got;
    int   n;
    @(negedge clk);
    fx1 = v.fx1; fx2 = v.fx2; fx3 = v.fx3;
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.e1 = v.e1; e.e2 = v.e2; e.e3 = v.e3; e.lat = v.lat;
    sb_q.push_back(e);
    // Inputs change after capture; the job must not see this.
    fx1 = $urandom; fx2 = $urandom; fx3 = $urandom;
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got none after %0d cycles expected %0d", n, v.lat);
      void'(sb_q.pop_front());
    end else begin
      got = sb_q.pop_front();
      last_e = got;
      check("f1", f1, got.e1);
      check("f2", f2, got.e2);
      check("f3", f3, got.e3);
      check("latency", 32'(n), 32'(got.lat));
      check("in_ready_done", 32'(in_ready), 32'd0);
      check("busy_done", 32'(busy), 32'd1);
    end
    if (release_out) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_cleared", 32'(out_valid), 32'd0);
      check("in_ready_back", 32'(in_ready), 32'd1);
      check("busy_cleared", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1.0, -2.5, 0
    vecs[0] = '{32'h0001_0000, 32'hFFFD_8000, 32'h0000_0000,
                32'h3F80_0000, 32'hC020_0000, 32'h0000_0000, 37};
    // most negative (lz=0), smallest positive (lz=31), carry into exponent
    vecs[1] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                32'hC700_0000, 32'h3780_0000,
                RNE ? 32'h4700_0000 : 32'h46FF_FFFF, 41};
    // tie round-down (even), tie round-up (odd), -2^-16
    vecs[2] = '{32'h0100_0001, 32'h0100_0003, 32'hFFFF_FFFF,
                32'h4380_0000, RNE ? 32'h4380_0002 : 32'h4380_0001,
                32'hB780_0000, 54};
    // 2.0, -1.0, 0.5
    vecs[3] = '{32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000,
                32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000, 54};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fx1 = '0; fx2 = '0; fx3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_f1", f1, 32'h0);
    check("rst_f2", f2, 32'h0);
    check("rst_f3", f3, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      run_job(vecs[i], 1'b1);
    end

    // Backpressure: result held, new offers ignored while DONE.
    run_job(vecs[3], 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      fx1 = $urandom; fx2 = $urandom; fx3 = $urandom;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_f1", f1, last_e.e1);
      check("bp_f2", f2, last_e.e2);
      check("bp_f3", f3, last_e.e3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_no_new_job", 32'(busy), 32'd0);
    check("bp_f1_hold", f1, last_e.e1);

    // Reset during NORM of lane 1.
    @(negedge clk);
    fx1 = vecs[0].fx1; fx2 = vecs[0].fx2; fx3 = vecs[0].fx3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    check("mid_f1_written", f1, 32'h3F80_0000);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_f1", f1, 32'h0);
    check("mid_rst_f2", f2, 32'h0);
    check("mid_rst_f3", f3, 32'h0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_job(vecs[1], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_composer.md
Name: float_composer

Overview:
- Reverse direction of the key-extraction stage: converts three signed fixed-point values into IEEE-754 single-precision words.
- Typical use: pixel- or key-derived perturbations are fed back as chaos-map state or initial conditions.
- One shared normalizer serves lanes 0, 1, 2 in sequence.
- Valid/ready handshake on input and output; one conversion job (3 lanes) in flight at a time.

Parameters:
- INT_W, 16, integer bits of the input two's-complement fixed-point value, sign bit included.
- FRAC_W, 16, fractional bits. W = INT_W + FRAC_W; legal range 25..48.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  high only in IDLE.
- fx1, fx2, fx3  in  W each  signed Q(INT_W).(FRAC_W) inputs.
- out_valid  out  1  f1..f3 valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- f1, f2, f3  out  32 each  float32 results.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (any time, including mid-job):
  - state goes to IDLE; lane counter to 0.
  - f1..f3 = 0; out_valid = 0; busy = 0; in_ready = 1 after reset release.
  - Any partial job is discarded.
- States: IDLE, LOAD, NORM, PACK, DONE.
- IDLE: on in_valid && in_ready at a clock edge, capture fx1..fx3 and lane = 0, then go to LOAD. in_valid in any other state is ignored.
- LOAD (1 cycle):
  - sign = fx[lane][W-1]; mag = |fx|, W-bit unsigned.
  - Most negative input gives mag = 2^(W-1); no overflow.
  - Zero counter cleared.
  - mag == 0 goes to PACK; otherwise goes to NORM.
- NORM (one bit per cycle):
  - If mag[W-1] == 1, go to PACK.
  - Else mag <<= 1 and lz += 1.
  - Dwell time = lz+1 cycles.
- PACK (1 cycle), result written to f[lane]:
  - Exponent = 127 + (INT_W-1) - lz; always within 1..254 for legal W, so no denormals or infinities are produced.
  - Mantissa = mag[W-2 : W-24]; round bit = mag[W-25]; sticky = OR of mag[W-26:0] (zero if W = 25).
  - Rounding is applied as defined under Optional Feature.
  - Zero input gives 32'h00000000 (never -0).
  - Lane < 2: lane += 1, go to LOAD. Lane == 2: go to DONE.
- DONE:
  - out_valid = 1; f1..f3 stable.
  - out_ready at a clock edge: out_valid goes to 0, next state IDLE.
  - A new job can be accepted no earlier than the cycle after.
- Latency:
  - Per lane: lz+3 cycles; a zero lane takes 2 cycles.
  - out_valid rises Σ lane cycles clock edges after the accepting edge.
- f1..f3 hold their previous values until overwritten by PACK of the corresponding lane.

Optional Feature:
- Macro FLOAT_COMPOSER_RNE_EN.
- Defined: round-to-nearest-even.
  - Increment mantissa if round && (sticky || mantissa[0]).
  - Mantissa carry-out sets mantissa to 0 and exponent += 1.
- Undefined: truncation; round and sticky bits ignored.

Test Plan:
- fx1=0x00010000, fx2=0xFFFD8000, fx3=0x00000000 -> f1=0x3F800000, f2=0xC0200000, f3=0x00000000; out_valid after 18+17+2=37 edges.
- fx=0x80000000 and 0x00000001 -> 0xC7000000 and 0x37800000; bounds of lz = 0 and lz = 31.
- fx=0x7FFFFFFF -> 0x47000000 with RNE_EN (carry into exponent); 0x46FFFFFF without.
- fx=0x01000001 -> 0x43800000 (tie, even, round down); fx=0x01000003 -> 0x43800002 with RNE_EN (tie, odd, round up), 0x43800001 without.
- Backpressure: hold out_ready=0 for 10 cycles and toggle in_valid with new data -> out_valid and f1..f3 stable, in_ready=0, new data ignored; out_ready=1 -> IDLE next edge.
- Assert rst during NORM of lane 1 -> f1..f3=0, out_valid=0, busy=0 immediately; a fresh job afterwards completes correctly.
